// File: rtl/gshare_btb_predictor_if.sv
// Fetch-side prediction and MEM-side resolution bundle for gshare_btb_predictor.
// master drives fetch/resolve inputs, slave is the predictor.
interface gshare_btb_predictor_if #(
  parameter int GHR_W = 4
);
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             csr_branch_signal;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_index;
  logic [GHR_W-1:0] pred_ghr;
  logic             res_valid;
  logic             res_is_jump;
  logic             res_taken;
  logic             res_mispredict;
  logic [31:0]      res_pc;
  logic [31:0]      res_target;
  logic [GHR_W-1:0] res_index;
  logic [GHR_W-1:0] res_ghr;
  logic [1:0]       flush;

  modport master (
    output fetch_valid, fetch_pc, csr_branch_signal,
    output res_valid, res_is_jump, res_taken, res_mispredict,
    output res_pc, res_target, res_index, res_ghr,
    input  pred_taken, pred_target, pred_index, pred_ghr, flush
  );

  modport slave (
    input  fetch_valid, fetch_pc, csr_branch_signal,
    input  res_valid, res_is_jump, res_taken, res_mispredict,
    input  res_pc, res_target, res_index, res_ghr,
    output pred_taken, pred_target, pred_index, pred_ghr, flush
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// gshare PHT + direct-mapped BTB predictor with speculative/architectural GHR.
// Define PRED_PERF_CNT_EN to add perf_branches / perf_mispredicts counters.
module gshare_btb_predictor #(
  parameter int GHR_W     = 4,
  parameter int BTB_IDX_W = 4,
  parameter int TAG_W     = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef PRED_PERF_CNT_EN
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts,
`endif
  gshare_btb_predictor_if.slave bus
);
  localparam int PHT_N = 1 << GHR_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  logic [1:0]       pht      [PHT_N];
  logic             btb_vld  [BTB_N];
  logic [TAG_W-1:0] btb_tag  [BTB_N];
  logic [31:0]      btb_tgt  [BTB_N];
  logic             btb_jmp  [BTB_N];
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] arch_ghr;

  logic [BTB_IDX_W-1:0] f_idx;
  logic [TAG_W-1:0]     f_tag;
  logic [GHR_W-1:0]     p_idx;
  logic                 hit;
  logic                 f_jmp;
  logic [BTB_IDX_W-1:0] r_idx;
  logic [TAG_W-1:0]     r_tag;

  assign f_idx = bus.fetch_pc[BTB_IDX_W+1:2];
  assign f_tag = bus.fetch_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign r_idx = bus.res_pc[BTB_IDX_W+1:2];
  assign r_tag = bus.res_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign p_idx = bus.fetch_pc[GHR_W+1:2] ^ spec_ghr;
  assign hit   = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_jmp = btb_jmp[f_idx];

  always_comb begin
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    bus.pred_index  = p_idx;
    bus.pred_ghr    = spec_ghr;
    bus.flush       = 2'b00;
    if (hit && !bus.csr_branch_signal && (f_jmp || pht[p_idx][1])) begin
      bus.pred_taken  = 1'b1;
      bus.pred_target = btb_tgt[f_idx];
    end
    if (!rst && bus.res_valid && bus.res_mispredict)
      bus.flush = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      for (int i = 0; i < BTB_N; i++) begin
        btb_vld[i] <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_jmp[i] <= 1'b0;
      end
      spec_ghr <= '0;
      arch_ghr <= '0;
    end else begin
      if (bus.res_valid && !bus.res_is_jump) begin
        if (bus.res_taken) begin
          if (pht[bus.res_index] != 2'b11)
            pht[bus.res_index] <= pht[bus.res_index] + 2'b01;
        end else if (pht[bus.res_index] != 2'b00) begin
          pht[bus.res_index] <= pht[bus.res_index] - 2'b01;
        end
        arch_ghr <= {arch_ghr[GHR_W-2:0], bus.res_taken};
      end
      if (bus.res_valid && bus.res_taken) begin
        btb_vld[r_idx] <= 1'b1;
        btb_tag[r_idx] <= r_tag;
        btb_tgt[r_idx] <= bus.res_target;
        btb_jmp[r_idx] <= bus.res_is_jump;
      end
      // repair wins over the speculative shift of a same-cycle fetch
      if (bus.res_valid && bus.res_mispredict)
        spec_ghr <= bus.res_is_jump ? bus.res_ghr
                  : {bus.res_ghr[GHR_W-2:0], bus.res_taken};
      else if (bus.fetch_valid && hit && !f_jmp && !bus.csr_branch_signal)
        spec_ghr <= {spec_ghr[GHR_W-2:0], bus.pred_taken};
    end
  end

`ifdef PRED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (bus.res_valid) begin
      if (perf_branches != 32'hFFFF_FFFF)
        perf_branches <= perf_branches + 32'd1;
      if (bus.res_mispredict && perf_mispredicts != 32'hFFFF_FFFF)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif
endmodule
